// File: rtl/rx_deframer.sv
// rx_deframer: HDLC-style bit deframer with zero-unstuffing,
// byte assembly, abort/length policing and CRC-16/X.25 check.
module rx_deframer #(
   parameter int MAX_LEN   = 1020,
   parameter bit CHECK_FCS = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bit_i,
   input  logic       bit_valid_i,
   output logic [7:0] byte_o,
   output logic       valid_o,
   output logic       begin_o,
   output logic       end_o,
   output logic       abort_o,
   output logic       crc_ok_o,
   output logic       in_frame_o
);

   localparam int          CW      = $clog2(MAX_LEN + 1);
   localparam logic [15:0] POLY    = 16'h8408;
   localparam logic [15:0] RESIDUE = 16'hF0B8;

   typedef enum logic [1:0] {
      S_HUNT,
      S_SYNC,
      S_FRAME
   } state_t;

   state_t        state_q;
   logic [2:0]    ones_q;
   logic [2:0]    ones_d;
   logic [2:0]    bit_cnt_q;
   logic [CW-1:0] byte_cnt_q;
   logic [7:0]    shreg_q;
   logic [7:0]    shreg_d;
   logic [15:0]   crc_q;
   logic [15:0]   crc_d;
   logic [15:0]   crc_byte_q;
   logic [7:0]    byte_q;
   logic          valid_q;
   logic          begin_q;
   logic          end_q;
   logic          abort_q;
   logic          crc_ok_q;
   logic          ev_data;
   logic          ev_flag;
   logic          ev_abort;
   logic          byte_done;
   logic          at_max;

   // Classify the raw bit against the run of preceding ones
   always_comb begin
      ev_data  = 1'b0;
      ev_flag  = 1'b0;
      ev_abort = 1'b0;
      ones_d   = 3'd0;
      if (bit_i) begin
         ones_d   = (ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1;
         ev_data  = (ones_q < 3'd6);
         ev_abort = (ones_q == 3'd6);
      end else begin
         ev_data = (ones_q < 3'd5);
         ev_flag = (ones_q == 3'd6);
      end
   end

   // Next shift register / CRC values for a data bit
   always_comb begin
      shreg_d   = {bit_i, shreg_q[7:1]};
      crc_d     = {1'b0, crc_q[15:1]}
                ^ ((crc_q[0] ^ bit_i) ? POLY : 16'h0000);
      byte_done = ev_data && (bit_cnt_q == 3'd7);
      at_max    = (int'(byte_cnt_q) >= MAX_LEN);
   end

   // Deframing FSM with all state and registered output pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_HUNT;
         ones_q     <= 3'd0;
         bit_cnt_q  <= 3'd0;
         byte_cnt_q <= '0;
         shreg_q    <= 8'h00;
         crc_q      <= 16'hFFFF;
         crc_byte_q <= 16'hFFFF;
         byte_q     <= 8'h00;
         valid_q    <= 1'b0;
         begin_q    <= 1'b0;
         end_q      <= 1'b0;
         abort_q    <= 1'b0;
         crc_ok_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         begin_q <= 1'b0;
         end_q   <= 1'b0;
         abort_q <= 1'b0;
         if (bit_valid_i) begin
            ones_q <= ones_d;
            if (ev_flag) begin
               crc_q     <= 16'hFFFF;
               bit_cnt_q <= 3'd0;
               state_q   <= S_SYNC;
               if (state_q == S_FRAME) begin
                  // flag's 0 and six 1s went in as data
                  if (bit_cnt_q == 3'd7) begin
                     end_q    <= 1'b1;
                     crc_ok_q <= (crc_byte_q == RESIDUE);
                  end else begin
                     abort_q <= 1'b1;
                  end
               end
            end else if (ev_abort) begin
               if (state_q == S_FRAME) begin
                  abort_q <= 1'b1;
               end
               state_q <= S_HUNT;
            end else if (ev_data && state_q != S_HUNT) begin
               shreg_q   <= shreg_d;
               crc_q     <= crc_d;
               bit_cnt_q <= bit_cnt_q + 3'd1;
               if (byte_done) begin
                  // checkpoint before flag bits pollute the CRC
                  crc_byte_q <= crc_d;
                  if (state_q == S_SYNC) begin
                     valid_q    <= 1'b1;
                     begin_q    <= 1'b1;
                     byte_q     <= shreg_d;
                     byte_cnt_q <= CW'(1);
                     state_q    <= S_FRAME;
                  end else if (at_max) begin
                     abort_q <= 1'b1;
                     state_q <= S_HUNT;
                  end else begin
                     valid_q    <= 1'b1;
                     byte_q     <= shreg_d;
                     byte_cnt_q <= byte_cnt_q + CW'(1);
                  end
               end
            end
         end
      end
   end

   assign byte_o     = byte_q;
   assign valid_o    = valid_q;
   assign begin_o    = begin_q;
   assign end_o      = end_q;
   assign abort_o    = abort_q;
   assign crc_ok_o   = CHECK_FCS ? crc_ok_q : 1'b1;
   assign in_frame_o = (state_q == S_FRAME);

endmodule
